// File: rtl/async_fifo_rd_ctrl.sv
// Read-domain controller for the dual-clock Gray-pointer FIFO: write-pointer sync, read pointer, level and flags.
// Optional sticky underflow flag is enabled by defining FIFO_RD_UNDERFLOW_EN.
module async_fifo_rd_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic              rclk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   ae_thresh,
  input  logic [ADDR_W:0]   wr_gray_async,
  input  logic              underflow_clr,
  output logic              rd_fire,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_gray,
  output logic [ADDR_W:0]   rd_level,
  output logic              fifo_empty,
  output logic              fifo_almost_empty,
  output logic              underflow
);

  localparam int PW = ADDR_W + 1;

  logic [SYNC_STAGES-1:0][PW-1:0] r_sync;
  logic [PW-1:0]                  w_wr_gray_s;
  logic [PW-1:0]                  w_wr_bin_s;
  logic [PW-1:0]                  r_rd_bin;
  logic [PW-1:0]                  w_rd_bin_nxt;
  logic [PW-1:0]                  r_rd_gray;
  logic [PW-1:0]                  w_level_nxt;
  logic [PW-1:0]                  r_rd_level;
  logic                           r_empty;
  logic                           r_almost_empty;

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], wr_gray_async};
    end
  end

  assign w_wr_gray_s = r_sync[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at and above it.
  genvar gi;
  generate
    for (gi = 0; gi <= ADDR_W; gi++) begin : g_gray2bin
      assign w_wr_bin_s[gi] = ^w_wr_gray_s[ADDR_W:gi];
    end
  endgenerate

  assign rd_fire      = rd_en & ~r_empty;
  assign w_rd_bin_nxt = r_rd_bin + PW'(rd_fire);
  // Modular subtraction absorbs pointer wrap on either side.
  assign w_level_nxt  = w_wr_bin_s - w_rd_bin_nxt;

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_bin       <= '0;
      r_rd_gray      <= '0;
      r_rd_level     <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
    end else begin
      r_rd_bin       <= w_rd_bin_nxt;
      r_rd_gray      <= w_rd_bin_nxt ^ (w_rd_bin_nxt >> 1);
      r_rd_level     <= w_level_nxt;
      r_empty        <= (w_level_nxt == '0);
      r_almost_empty <= (w_level_nxt <= ae_thresh);
    end
  end

  assign rd_addr           = r_rd_bin[ADDR_W-1:0];
  assign rd_gray           = r_rd_gray;
  assign rd_level          = r_rd_level;
  assign fifo_empty        = r_empty;
  assign fifo_almost_empty = r_almost_empty;

`ifdef FIFO_RD_UNDERFLOW_EN
  logic r_underflow;

  // Set has priority over clear so an attempt in the clearing cycle is not lost.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_underflow <= 1'b0;
    end else if (rd_en & r_empty) begin
      r_underflow <= 1'b1;
    end else if (underflow_clr) begin
      r_underflow <= 1'b0;
    end
  end

  assign underflow = r_underflow;
`else
  logic w_unused_clr;

  assign w_unused_clr = underflow_clr;
  assign underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed plus randomized bench for async_fifo_rd_ctrl against a pointer-count reference model.
module tb_async_fifo_rd_ctrl;

  localparam int ADDR_W = 4;
  localparam int SYNC   = 2;
  localparam int DEPTH  = 16;
`ifdef FIFO_RD_UNDERFLOW_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  logic              rclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd_en = 1'b0;
  logic              underflow_clr = 1'b0;
  logic [ADDR_W:0]   ae_thresh = 5'd2;
  logic [ADDR_W:0]   wr_gray_async = '0;
  logic              rd_fire;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   rd_gray;
  logic [ADDR_W:0]   rd_level;
  logic              fifo_empty;
  logic              fifo_almost_empty;
  logic              underflow;

  async_fifo_rd_ctrl #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)) dut (
    .rclk              (rclk),
    .rst_n             (rst_n),
    .rd_en             (rd_en),
    .ae_thresh         (ae_thresh),
    .wr_gray_async     (wr_gray_async),
    .underflow_clr     (underflow_clr),
    .rd_fire           (rd_fire),
    .rd_addr           (rd_addr),
    .rd_gray           (rd_gray),
    .rd_level          (rd_level),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .underflow         (underflow)
  );

  always #5 rclk = ~rclk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: unbounded write/read counts; the reader sees the write count SYNC edges late.
  int wp = 0;
  int rp = 0;
  int hist[$];
  int exp_level = 0;
  bit exp_empty = 1'b1;
  bit exp_ae    = 1'b1;
  bit exp_uf    = 1'b0;
  bit exp_fire  = 1'b0;

  function automatic logic [4:0] gray(int b);
    logic [4:0] v;
    v = 5'(b % 32);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_wr(int p);
    wp = p;
    wr_gray_async = gray(p);
  endtask

  task automatic check_outputs();
    chk("rd_addr",  32'(rd_addr),           32'(rp % DEPTH));
    chk("rd_gray",  32'(rd_gray),           32'(gray(rp)));
    chk("rd_level", 32'(rd_level),          32'(exp_level));
    chk("empty",    32'(fifo_empty),        32'(exp_empty));
    chk("a_empty",  32'(fifo_almost_empty), 32'(exp_ae));
    chk("uflow",    32'(underflow),         32'(exp_uf));
  endtask

  task automatic reset_model();
    wp = 0;
    rp = 0;
    hist.delete();
    exp_level = 0;
    exp_empty = 1'b1;
    exp_ae    = 1'b1;
    exp_uf    = 1'b0;
    wr_gray_async = '0;
  endtask

  // One rclk edge: check the combinational accept, advance the model, check registered outputs.
  task automatic step();
    int vis;
    exp_fire = rd_en && !exp_empty;
    #1 chk("rd_fire", 32'(rd_fire), 32'(exp_fire));
    @(posedge rclk);
    hist.push_back(wp);
    if (UF_EN) exp_uf = (rd_en && exp_empty) || (exp_uf && !underflow_clr);
    if (exp_fire) rp++;
    vis = (hist.size() > SYNC) ? hist[hist.size() - 1 - SYNC] : 0;
    exp_level = vis - rp;
    exp_empty = (exp_level == 0);
    exp_ae    = (exp_level <= int'(ae_thresh));
    #1 check_outputs();
  endtask

  initial begin
    logic [4:0] gseq [3];
    int rdp [5];
    int thr [5];
    int t_goal;
    int iter;

    gseq = '{5'b00001, 5'b00011, 5'b00010};
    rdp  = '{2, 8, 5, 1, 5};
    thr  = '{0, 3, 8, 16, 20};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge rclk);
    #1 check_outputs();
    chk("rst_fire", 32'(rd_fire), 32'd0);
    @(negedge rclk);
    rst_n = 1'b1;

    // Three entries become visible after the sync latency
    ae_thresh = 5'd2;
    set_wr(3);
    repeat (3) step();
    chk("fill_level", 32'(rd_level), 32'd3);
    chk("fill_empty", 32'(fifo_empty), 32'd0);
    chk("fill_ae",    32'(fifo_almost_empty), 32'd0);

    // Drain three
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("drain_gray",  32'(rd_gray), 32'(gseq[i]));
      chk("drain_level", 32'(rd_level), 32'(2 - i));
      chk("drain_ae",    32'(fifo_almost_empty), 32'd1);
    end
    chk("drain_empty", 32'(fifo_empty), 32'd1);

    // Underflow attempt, stickiness, clear, set-beats-clear
    step();
    chk("uf_addr_held", 32'(rd_addr), 32'd3);
    chk("uf_set", 32'(underflow), 32'(UF_EN));
    rd_en = 1'b0;
    repeat (2) step();
    chk("uf_sticky", 32'(underflow), 32'(UF_EN));
    underflow_clr = 1'b1;
    step();
    chk("uf_clear", 32'(underflow), 32'd0);
    rd_en = 1'b1;
    step();
    chk("uf_set_wins", 32'(underflow), 32'(UF_EN));
    rd_en = 1'b0;
    step();
    underflow_clr = 1'b0;

    // Randomized traffic across several almost-empty thresholds and read rates
    for (int ph = 0; ph < 5; ph++) begin
      ae_thresh = 5'(thr[ph]);
      for (int i = 0; i < 150; i++) begin
        rd_en = ($urandom_range(0, 9) < rdp[ph]);
        underflow_clr = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 1) == 1 && (wp - rp) < DEPTH) set_wr(wp + 1);
        step();
      end
    end
    rd_en = 1'b0;
    underflow_clr = 1'b0;

    // Wrap: park both pointers at 30 (mod 32), then write 30->31->0->1->2
    ae_thresh = 5'd2;
    t_goal = rp - (rp % 32) + 30;
    while (t_goal < wp) t_goal += 32;
    iter = 0;
    while (!(rp == t_goal && wp == t_goal) && iter < 400) begin
      rd_en = (rp < t_goal);
      if (wp < t_goal && (wp - rp) < DEPTH) set_wr(wp + 1);
      step();
      iter++;
    end
    chk("wrap_setup", 32'(iter < 400), 32'd1);
    rd_en = 1'b0;
    repeat (SYNC + 1) step();
    chk("wrap_start_gray", 32'(rd_gray), 32'(gray(30)));
    for (int i = 0; i < 4; i++) begin
      set_wr(wp + 1);
      step();
    end
    repeat (3) step();
    chk("wrap_level", 32'(rd_level), 32'd4);
    rd_en = 1'b1;
    repeat (4) step();
    rd_en = 1'b0;
    chk("wrap_gray",  32'(rd_gray), 32'h03);
    chk("wrap_addr",  32'(rd_addr), 32'd2);
    chk("wrap_empty", 32'(fifo_empty), 32'd1);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) begin
      set_wr(wp + 1);
      step();
    end
    repeat (3) step();
    chk("pre_rst_level", 32'(rd_level), 32'd5);
    rd_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(rd_level), 32'd0);
    chk("arst_empty", 32'(fifo_empty), 32'd1);
    chk("arst_ae",    32'(fifo_almost_empty), 32'd1);
    chk("arst_gray",  32'(rd_gray), 32'd0);
    chk("arst_addr",  32'(rd_addr), 32'd0);
    chk("arst_uf",    32'(underflow), 32'd0);
    chk("arst_fire",  32'(rd_fire), 32'd0);
    reset_model();
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rst_n = 1'b1;
    repeat (5) step();
    chk("post_rst_addr", 32'(rd_addr), 32'd0);
    rd_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/async_fifo_rd_ctrl.md
Name: async_fifo_rd_ctrl

Overview:
Read-domain controller for the team's dual-clock Gray-pointer FIFO, and the next generation of the current read-side block. It synchronises the write Gray pointer through a parametrised synchroniser chain and owns the read pointer, read address, fill level, empty and programmable almost-empty flags. It gates reads against underflow and optionally flags underflow attempts. It sits between the read-side consumer and the dual-port RAM read address, and exports rd_gray to the write-domain controller.

Parameters:
- ADDR_W, 4, RAM address width; depth = 2^ADDR_W, pointers are ADDR_W+1 bits.
- SYNC_STAGES, 2, number of synchroniser flops on wr_gray_async; legal range 2..4.

Ports:
- rclk  in  1  read clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_en  in  1  read request from consumer.
- ae_thresh  in  ADDR_W+1  almost-empty threshold, quasi-static.
- wr_gray_async  in  ADDR_W+1  write Gray pointer from wclk domain.
- underflow_clr  in  1  clears the sticky underflow flag.
- rd_fire  out  1  accepted read this cycle = rd_en & ~fifo_empty (combinational).
- rd_addr  out  ADDR_W  RAM read address = rd_bin[ADDR_W-1:0].
- rd_gray  out  ADDR_W+1  registered Gray read pointer, sent to wclk domain.
- rd_level  out  ADDR_W+1  registered readable-entry count, 0..2^ADDR_W.
- fifo_empty  out  1  registered empty flag.
- fifo_almost_empty  out  1  registered, high when level <= ae_thresh.
- underflow  out  1  sticky: rd_en seen while fifo_empty.

Behaviour:
- Reset values (all flops, async on rst_n low): sync chain 0, rd_bin 0, rd_gray 0, rd_level 0, fifo_empty 1, fifo_almost_empty 1, underflow 0.
- Synchroniser: SYNC_STAGES flops in series on wr_gray_async. The last stage is wr_gray_s. wr_bin_s = gray-to-binary(wr_gray_s).
- Read pointer: rd_bin_nxt = rd_bin + rd_fire, modulo 2^(ADDR_W+1). rd_bin <= rd_bin_nxt. rd_gray <= rd_bin_nxt ^ (rd_bin_nxt >> 1), so rd_gray always matches rd_bin.
- Level: level_nxt = (wr_bin_s - rd_bin_nxt), modulo 2^(ADDR_W+1). No MSB special-casing; natural wrap handles pointer roll-over.
- Registered outputs each cycle:
  - rd_level <= level_nxt
  - fifo_empty <= (level_nxt == 0)
  - fifo_almost_empty <= (level_nxt <= ae_thresh)
- Latency: a wr_gray_async change reaches rd_level and the flags after SYNC_STAGES+1 rclk edges. A read updates rd_addr, rd_gray, rd_level and the flags on the same edge that consumes it.
- Data valid: RAM data at rd_addr is the head entry whenever fifo_empty=0. rd_fire marks consumption.
- Underflow guard: rd_en while fifo_empty=1 does not move rd_bin, and rd_fire=0.
- Simultaneous write-sync update and read: both fold into level_nxt in one cycle; the level is never double-counted.
- Wrap-around: rd_bin rolls from 2^(ADDR_W+1)-1 to 0. Level stays correct across either pointer wrapping.
- Conservatism: empty may deassert late, bounded by sync latency, but never early. Level never exceeds 2^ADDR_W given a legal writer.
- ae_thresh >= 2^ADDR_W forces fifo_almost_empty=1 permanently. This is legal.
- Reset mid-operation: all outputs return to reset values immediately, without waiting for a clock edge. The write side must also be reset.

Optional Feature:
- Macro: FIFO_RD_UNDERFLOW_EN.
- Defined:
  - underflow <= 1 on the edge after any cycle with rd_en & fifo_empty.
  - underflow <= 0 when underflow_clr=1.
  - Set wins when set and clear occur in the same cycle.
- Undefined: underflow is tied to 0, underflow_clr is ignored, and no flop is inferred. The read gating is unchanged.

Test Plan:
- Reset: hold rst_n=0, then release -> fifo_empty=1, fifo_almost_empty=1, rd_level=0, rd_gray=5'b00000, rd_addr=0, underflow=0.
- ADDR_W=4, SYNC_STAGES=2, ae_thresh=2; drive wr_gray_async=5'b00010 (bin 3) -> 3 edges later rd_level=3, fifo_empty=0, fifo_almost_empty=0.
- From 3 entries, hold rd_en for 3 cycles:
  - rd_addr shows 0,1,2 on successive cycles.
  - rd_gray after each read = 00001, 00011, 00010.
  - rd_level = 2, 1, 0.
  - fifo_almost_empty=1 after the first read; fifo_empty=1 after the third.
- rd_en=1 while empty -> rd_fire=0, rd_addr is held. With FIFO_RD_UNDERFLOW_EN, underflow=1 next edge and stays set until a one-cycle underflow_clr pulse. If underflow_clr and rd_en&empty occur in the same cycle, underflow stays 1.
- Wrap: set rd_bin=30, then drive the write pointer 30->31->0->1->2 in Gray -> rd_level=4 after sync. Read 4 -> rd_bin=2, rd_gray=5'b00011, fifo_empty=1.
- Pull rst_n low mid-burst with rd_en=1 and rd_level=5 -> outputs go to reset values asynchronously, before the next rclk edge. After release, no phantom reads occur.
